// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data side has priority; a saturating starvation counter forces a fetch grant.
module imem_dmem_arbiter #(
  parameter int WORD       = 32,
  parameter int ADDR       = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [ADDR-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [WORD-1:0] if_rdata_o,
  input  logic            flush_i,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [ADDR-1:0] d_addr_i,
  input  logic [WORD-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [WORD-1:0] d_rdata_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic [WORD-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e     rd_owner, rd_owner_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Fetch wins a contested cycle only once the counter has saturated.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (!reset) begin
      if (if_req_i && !flush_i && (!d_req_i || starve_cnt >= STARVE_LIM)) begin
        if_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    rd_owner_nxt   = OWN_NONE;
    // A redirect freezes the count so the new fetch stream inherits it.
    if (!flush_i) begin
      if (!if_req_i || if_gnt_o) begin
        starve_cnt_nxt = 4'd0;
      end else if (starve_cnt < STARVE_LIM) begin
        starve_cnt_nxt = starve_cnt + 4'd1;
      end
    end
    if (if_gnt_o) begin
      rd_owner_nxt = OWN_IF;
    end else if (d_gnt_o && !d_we_i) begin
      rd_owner_nxt = OWN_D;
    end
  end

  always_comb begin
    mem_en_o    = if_gnt_o | d_gnt_o;
    mem_we_o    = d_gnt_o & d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
    end else if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  assign d_rvalid_o  = !reset && (rd_owner == OWN_D);
  assign if_rvalid_o = !reset && (rd_owner == OWN_IF) && !flush_i;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule
